// File: rtl/seq_right_shifter_pkg.sv
// -----------------------------------------------------------------------------
// seq_right_shifter_pkg
//
// Shared constants and types for the sequential right shifter.
//   DATA_W  : datapath width (operand and result)
//   SHAMT_W : width of the shift amount / iteration counter
//   state_e : control FSM encoding (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package seq_right_shifter_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [SHAMT_W-1:0] shamt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage : seq_right_shifter_pkg

// File: rtl/seq_right_shifter_one_bit.sv
// -----------------------------------------------------------------------------
// oneBitRightShifter
//
// Combinational 32-bit logical right shift by exactly one position. Bit 31 of
// the output is always zero; callers that need a sign fill apply it outside.
//
// Ports
//   number_i : operand to shift
//   result_o : operand >> 1 (zero fill)
// -----------------------------------------------------------------------------
module oneBitRightShifter
   import seq_right_shifter_pkg::*;
(
   input  logic [DATA_W-1:0] number_i,
   output logic [DATA_W-1:0] result_o
);

   // The LSB falls off the end of the shift by design.
   logic unused_lsb;
   assign unused_lsb = number_i[0];

   assign result_o = {1'b0, number_i[DATA_W-1:1]};

endmodule : oneBitRightShifter

// File: rtl/seq_right_shifter.sv
// -----------------------------------------------------------------------------
// seq_right_shifter
//
// Iterative right shifter: one bit per clock. An accepted start captures the
// operand, shift amount and mode; the block then shifts once per cycle in
// SHIFT and pulses done in DONE. A new start is accepted in IDLE or DONE, so
// back-to-back operations need no idle cycle.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   start  : request pulse, ignored while busy
//   number : operand, captured on an accepted start
//   shamt  : shift amount 0..31, captured on an accepted start
//   arith  : 0 = logical (zero fill), 1 = arithmetic (sign fill)
//   result : registered working value
//   busy   : high while in SHIFT
//   done   : one-cycle pulse, high while in DONE
// -----------------------------------------------------------------------------
module seq_right_shifter
   import seq_right_shifter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DATA_W-1:0]  number,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic [DATA_W-1:0]  result,
   output logic               busy,
   output logic               done
);

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   state_e state_q, state_d;
   data_t  work_q,  work_d;
   shamt_t cnt_q,   cnt_d;
   logic   arith_q, arith_d;

   data_t  step_raw;   // one-bit shift of work_q, zero filled
   data_t  step_out;   // one-bit shift with the mode-dependent fill applied
   logic   fill_bit;
   logic   accept;

   // A start is only honoured when no shift is in flight.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   // --------------------------------------------------------------------------
   // One-bit shift step
   // --------------------------------------------------------------------------
   oneBitRightShifter u_one_bit (
      .number_i (work_q),
      .result_o (step_raw)
   );

   // During an arithmetic shift bit 31 of the working register is re-filled
   // with itself every step, so it always equals bit 31 of the captured
   // operand. For logical shifts the mode flag forces a zero fill.
   assign fill_bit = arith_q & work_q[DATA_W-1];

   // The instance always zero-fills bit 31, so OR-ing inserts the fill.
   assign step_out = {step_raw[DATA_W-1] | fill_bit, step_raw[DATA_W-2:0]};

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path through
   // the block leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Counter is never zero here; the step taking it from 1 to 0 is
            // the last one.
            if (cnt_q == shamt_t'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               state_d = (shamt == '0) ? DONE : SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath next-value logic
   // --------------------------------------------------------------------------
   always_comb begin
      work_d  = work_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
      if (accept) begin
         work_d  = number;
         cnt_d   = shamt;
         arith_d = arith;
      end else if (state_q == SHIFT) begin
         work_d = step_out;
         cnt_d  = cnt_q - shamt_t'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      result = work_q;
      busy   = (state_q == SHIFT);
      done   = (state_q == DONE);
   end

endmodule : seq_right_shifter

// File: tb/tb_seq_right_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_right_shifter
//
// Self-checking bench for seq_right_shifter. Inputs are driven and outputs
// sampled on the falling clock edge. Expected results come from a plain
// arithmetic model (>> / >>>), expected latency from shamt + 1.
// -----------------------------------------------------------------------------
module tb_seq_right_shifter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] number;
   logic [4:0]  shamt;
   logic        arith;
   logic [31:0] result;
   logic        busy;
   logic        done;

   int n_total = 0;
   int n_pass  = 0;

   seq_right_shifter dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .number (number),
      .shamt  (shamt),
      .arith  (arith),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: srl / sra by plain operators.
   function automatic logic [31:0] ref_shift(input logic [31:0] num,
                                             input logic [4:0]  sa,
                                             input logic        ar);
      if (ar) return 32'($signed(num) >>> sa);
      return num >> sa;
   endfunction

   // Issue one operation from a falling edge and wait (bounded) for done.
   // lat = number of rising edges from the accepting edge to done, -1 on
   // timeout. Optionally scrambles the inputs right after acceptance.
   task automatic do_op(input  logic [31:0] num,
                        input  logic [4:0]  sa,
                        input  logic        ar,
                        input  bit          scramble,
                        output int          lat,
                        output logic [31:0] res,
                        output int          busy_n);
      start  = 1'b1;
      number = num;
      shamt  = sa;
      arith  = ar;
      lat    = -1;
      res    = 32'hxxxx_xxxx;
      busy_n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            if (scramble) begin
               number = $urandom;
               shamt  = 5'($urandom);
               arith  = 1'($urandom);
            end
         end
         if (busy) busy_n++;
         if (done) begin
            lat = k;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; number = 32'hA5A5_A5A5; shamt = 5'd3; arith = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      // Reset wins over a simultaneous start.
      start = 1'b1; number = 32'h1234_5678; shamt = 5'd0;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL rst_prio_done: got %b want 0", done); else n_pass++;
      n_total++; if (result !== 32'h0) $display("FAIL rst_prio_result: got %h want 00000000", result); else n_pass++;
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int          lat;
      int          bn;
      logic [31:0] res;
      // Logical shift.
      do_op(32'hF000_0000, 5'd4, 1'b0, 1'b0, lat, res, bn);
      n_total++; if (lat !== 5) $display("FAIL srl_latency: got %0d want 5", lat); else n_pass++;
      n_total++; if (res !== 32'h0F00_0000) $display("FAIL srl_result: got %h want 0f000000", res); else n_pass++;
      n_total++; if (bn !== 4) $display("FAIL srl_busy_cycles: got %0d want 4", bn); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL srl_done_pulse: got %b want 0", done); else n_pass++;
      n_total++; if (result !== 32'h0F00_0000) $display("FAIL srl_hold: got %h want 0f000000", result); else n_pass++;
      // Arithmetic shift, maximum amount.
      do_op(32'h8000_0000, 5'd31, 1'b1, 1'b0, lat, res, bn);
      n_total++; if (lat !== 32) $display("FAIL sra_latency: got %0d want 32", lat); else n_pass++;
      n_total++; if (res !== 32'hFFFF_FFFF) $display("FAIL sra_result: got %h want ffffffff", res); else n_pass++;
      @(negedge clk);
      // Zero shift.
      do_op(32'h1234_5678, 5'd0, 1'b0, 1'b0, lat, res, bn);
      n_total++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
      n_total++; if (res !== 32'h1234_5678) $display("FAIL zero_result: got %h want 12345678", res); else n_pass++;
      n_total++; if (bn !== 0) $display("FAIL zero_busy_cycles: got %0d want 0", bn); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      int          lat = -1;
      int          n_done = 0;
      logic [31:0] res = 32'h0;
      start = 1'b1; number = 32'h0000_FF00; shamt = 5'd8; arith = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            start = 1'b1; number = 32'hFFFF_FFFF; shamt = 5'd31; arith = 1'b1;
         end
         if (k == 4) start = 1'b0;
         if (done) begin
            n_done++;
            if (lat < 0) begin
               lat = k;
               res = result;
            end
         end
      end
      n_total++; if (lat !== 9) $display("FAIL ignore_latency: got %0d want 9", lat); else n_pass++;
      n_total++; if (res !== 32'h0000_00FF) $display("FAIL ignore_result: got %h want 000000ff", res); else n_pass++;
      n_total++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit   seen = 1'b0;
      int   lat2 = -1;
      logic b2b_busy = 1'b0;
      start = 1'b1; number = 32'h0000_0100; shamt = 5'd3; arith = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_total++; if (seen !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", seen); else n_pass++;
      n_total++; if (result !== 32'h0000_0020) $display("FAIL b2b_first_result: got %h want 00000020", result); else n_pass++;
      // Start held during the done cycle.
      start = 1'b1; number = 32'h0000_0010; shamt = 5'd2; arith = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start    = 1'b0;
            b2b_busy = busy;
         end
         if (done) begin
            lat2 = k;
            break;
         end
      end
      n_total++; if (b2b_busy !== 1'b1) $display("FAIL b2b_no_idle: got %b want 1", b2b_busy); else n_pass++;
      n_total++; if (lat2 !== 3) $display("FAIL b2b_latency: got %0d want 3", lat2); else n_pass++;
      n_total++; if (result !== 32'h0000_0004) $display("FAIL b2b_second_result: got %h want 00000004", result); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", done); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int          n_done = 0;
      int          lat;
      int          bn;
      logic [31:0] res;
      start = 1'b1; number = 32'hDEAD_BEEF; shamt = 5'd10; arith = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h want 00000000", result); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      n_total++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d want 0", n_done); else n_pass++;
      do_op(32'h8000_0F00, 5'd6, 1'b1, 1'b0, lat, res, bn);
      n_total++; if (lat !== 7) $display("FAIL rstmid_after_latency: got %0d want 7", lat); else n_pass++;
      n_total++; if (res !== 32'hFE00_003C) $display("FAIL rstmid_after_result: got %h want fe00003c", res); else n_pass++;
      @(negedge clk);
   endtask

   // Every shift amount with random operands, then random ops whose inputs
   // are scrambled right after acceptance.
   task automatic test_random();
      int          lat;
      int          bn;
      logic [31:0] res;
      logic [31:0] num;
      logic [4:0]  sa;
      logic        ar;
      logic [31:0] exp_v;
      for (int i = 0; i < 48; i++) begin
         num   = $urandom;
         sa    = (i < 32) ? 5'(i) : 5'($urandom_range(0, 31));
         ar    = 1'($urandom);
         exp_v = ref_shift(num, sa, ar);
         do_op(num, sa, ar, (i >= 32), lat, res, bn);
         n_total++; if (lat !== int'(sa) + 1) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, int'(sa) + 1); else n_pass++;
         n_total++; if (res !== exp_v) $display("FAIL rnd_result[%0d] num=%h sa=%0d ar=%b: got %h want %h", i, num, sa, ar, res, exp_v); else n_pass++;
         n_total++; if (bn !== int'(sa)) $display("FAIL rnd_busy_cycles[%0d]: got %0d want %0d", i, bn, int'(sa)); else n_pass++;
         @(negedge clk);
         n_total++; if (done !== 1'b0 || result !== exp_v) $display("FAIL rnd_idle_hold[%0d]: got done=%b result=%h want done=0 result=%h", i, done, result, exp_v); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_seq_right_shifter
